spi_tx_queue: RTL and testbench

Parametrised SPI transmit master with an internal word queue, generalising the current fixed 24-bit, 4-word top/bus/spi_tx path. Upstream logic pushes words through a valid/ready write port. The block drains them in order as SPI frames with configurable word width, queue depth, SCLK rate, clock polarity, bit order and inter-frame chip-select gap. It sits between control logic and the external SPI pins and replaces the rotating register bank plus bus handshake.

---
 rtl/spi_tx_queue.sv | 150 +++++++++++++++
 tb/tb_spi_tx_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_queue.sv
// SPI transmit master fed by a DEPTH-word queue; frames drain in order, cs low one cycle after the pop.
// Writes are back-pressured by wr_ready (= !full); flush/RST abort the frame and empty the queue.
module spi_tx_queue #(
  parameter int DATA_W    = 24,
  parameter int DEPTH     = 4,
  parameter int CLK_DIV   = 2,
  parameter int CS_GAP    = 2,
  parameter bit CPOL      = 1'b0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       busy,
  output logic                       word_done,
  output logic                       spi_cs,
  output logic                       spi_clk,
  output logic                       spi_data
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH+1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [LW-1:0]     r_level, w_level_nxt;
  logic              r_full, r_empty, r_wr_ready;
  logic [DATA_W-1:0] r_shift;
  logic [DIV_W-1:0]  r_div;
  logic              r_phase;
  logic [BIT_W-1:0]  r_bit;
  logic [GAP_W-1:0]  r_gap;
  logic              r_cs, r_sclk, r_mosi, r_done, r_busy;
  logic              w_push, w_pop, w_half_end, w_frame_end, w_gap_end;
  logic              w_first_bit, w_next_bit;

  always_comb begin
    w_push      = wr_valid && !r_full && !flush;
    w_pop       = (r_state == S_IDLE) && !r_empty && !flush;
    w_half_end  = (r_div == DIV_W'(CLK_DIV-1));
    w_frame_end = (r_state == S_SHIFT) && w_half_end && r_phase && (r_bit == BIT_W'(DATA_W-1));
    w_gap_end   = (r_state == S_GAP) && (r_gap == GAP_W'(CS_GAP-1));
    w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
    w_first_bit = MSB_FIRST ? r_mem[r_rptr][DATA_W-1] : r_mem[r_rptr][0];
    w_next_bit  = MSB_FIRST ? r_shift[DATA_W-2] : r_shift[1];
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_pop)       w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_frame_end) w_state_nxt = S_GAP;
      S_GAP:   if (w_gap_end)   w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST || flush) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  // Storage is not reset: pointers and level alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (RST || flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_wr_ready <= 1'b1;
      r_shift    <= '0;
      r_div      <= '0;
      r_phase    <= 1'b0;
      r_bit      <= '0;
      r_gap      <= '0;
      r_cs       <= 1'b1;
      r_sclk     <= CPOL;
      r_mosi     <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_level    <= w_level_nxt;
      r_full     <= (w_level_nxt == LW'(DEPTH));
      r_empty    <= (w_level_nxt == '0);
      r_wr_ready <= (w_level_nxt != LW'(DEPTH));
      case (r_state)
        S_IDLE: if (w_pop) begin
          r_shift <= r_mem[r_rptr];
          r_mosi  <= w_first_bit;
          r_cs    <= 1'b0;
          r_sclk  <= CPOL;
          r_div   <= '0;
          r_phase <= 1'b0;
          r_bit   <= '0;
          r_busy  <= 1'b1;
        end
        S_SHIFT: if (w_half_end) begin
          r_div <= '0;
          if (!r_phase) begin
            r_phase <= 1'b1;
            r_sclk  <= ~CPOL;
          end else begin
            // Second half ends: SCLK returns to idle and the next bit is launched.
            r_phase <= 1'b0;
            r_sclk  <= CPOL;
            if (w_frame_end) begin
              r_cs   <= 1'b1;
              r_mosi <= 1'b0;
              r_done <= 1'b1;
              r_gap  <= '0;
            end else begin
              r_bit   <= r_bit + BIT_W'(1);
              r_shift <= MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
              r_mosi  <= w_next_bit;
            end
          end
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
        S_GAP: begin
          if (w_gap_end) r_busy <= 1'b0;
          else           r_gap  <= r_gap + GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign wr_ready  = r_wr_ready;
  assign level     = r_level;
  assign busy      = r_busy;
  assign word_done = r_done;
  assign spi_cs    = r_cs;
  assign spi_clk   = r_sclk;
  assign spi_data  = r_mosi;
endmodule

// File: tb/tb_spi_tx_queue.sv
// Bench for spi_tx_queue: a default instance and an 8-bit LSB-first CPOL=1 instance, each decoded off the pins.
module tb_spi_tx_queue;
  localparam int DW = 24, DEPTH = 4, CLK_DIV = 2, CS_GAP = 2;
  localparam bit CPOL = 1'b0;
  localparam int BW = 8;
  localparam int FRAME0 = DW*2*CLK_DIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          RST = 1'b1, flush = 1'b0, wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready, busy, word_done, spi_cs, spi_clk, spi_data;
  logic [2:0]    level;

  logic          b_flush = 1'b0, b_wr_valid = 1'b0;
  logic [BW-1:0] b_wr_data = '0;
  logic          b_wr_ready, b_busy, b_done, b_cs, b_sclk, b_mosi;
  logic [2:0]    b_level;

  spi_tx_queue #(.DATA_W(DW), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP),
                 .CPOL(CPOL), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .RST(RST), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .flush(flush), .level(level), .busy(busy), .word_done(word_done),
    .spi_cs(spi_cs), .spi_clk(spi_clk), .spi_data(spi_data));

  spi_tx_queue #(.DATA_W(BW), .DEPTH(4), .CLK_DIV(1), .CS_GAP(2),
                 .CPOL(1'b1), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .RST(RST), .wr_data(b_wr_data), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
    .flush(b_flush), .level(b_level), .busy(b_busy), .word_done(b_done),
    .spi_cs(b_cs), .spi_clk(b_sclk), .spi_data(b_mosi));

  int checks = 0, failures = 0;
  logic [DW-1:0] q0[$];
  logic [BW-1:0] q1[$];
  int nbits0 = 0, low0 = 0, frames0 = 0, frames1 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor for the default instance: frames are rebuilt from the pins.
  logic          pcs0 = 1'b1, pclk0 = CPOL, pmosi0 = 1'b0;
  int            hi0 = 0;
  bit            norm0 = 1'b0, gapchk0 = 1'b0, have0 = 1'b0;
  logic [DW-1:0] cap0 = '0, exp0 = '0;
  initial forever begin
    @(posedge clk); #1;
    if (RST || flush) begin
      chk("rst_cs", spi_cs, 1); chk("rst_sclk", spi_clk, CPOL); chk("rst_mosi", spi_data, 0);
      chk("rst_level", level, 0); chk("rst_ready", wr_ready, 1); chk("rst_busy", busy, 0);
      chk("rst_done", word_done, 0);
      norm0 = 0; gapchk0 = 0; have0 = 0; hi0 = 0; nbits0 = 0;
    end else begin
      chk("word_done", word_done, (!pcs0 && spi_cs));
      if (pcs0 && !spi_cs) begin
        if (gapchk0) chk("cs_gap_min", (hi0 >= CS_GAP+1), 1);
        chk("pop_model_nonempty", (q0.size() > 0), 1);
        if (q0.size() > 0) exp0 = q0.pop_front();
        have0 = 1; cap0 = '0; nbits0 = 0; low0 = 0;
      end
      if (!spi_cs) begin
        low0++;
        if (!pcs0 && spi_data !== pmosi0)
          chk("mosi_change_on_idle_edge", (pclk0 != CPOL && spi_clk == CPOL), 1);
        if (pclk0 == CPOL && spi_clk != CPOL) begin
          cap0 = {cap0[DW-2:0], spi_data};
          nbits0++;
        end
      end else begin
        chk("idle_sclk", spi_clk, CPOL); chk("idle_mosi", spi_data, 0);
        if (!pcs0) begin
          chk("frame_bits", nbits0, DW); chk("frame_cs_low", low0, FRAME0);
          chk("frame_have", have0, 1);
          if (have0) chk("frame_data", cap0, exp0);
          frames0++; have0 = 0; norm0 = 1; gapchk0 = 1; hi0 = 1;
        end else hi0++;
      end
      chk("busy", busy, (!spi_cs || (norm0 && hi0 <= CS_GAP)));
      chk("level", level, q0.size());
      chk("wr_ready", wr_ready, (q0.size() < DEPTH));
    end
    pcs0 = spi_cs; pclk0 = spi_clk; pmosi0 = spi_data;
  end

  // Monitor for the LSB-first CPOL=1 instance: slave samples on falling SCLK.
  logic          pcs1 = 1'b1, pclk1 = 1'b1;
  int            nb1 = 0, low1 = 0;
  bit            have1 = 1'b0;
  logic [BW-1:0] cap1 = '0, exp1 = '0;
  initial forever begin
    @(posedge clk); #1;
    if (RST) begin
      chk("b_rst_cs", b_cs, 1); chk("b_rst_sclk", b_sclk, 1); chk("b_rst_mosi", b_mosi, 0);
      have1 = 0;
    end else begin
      chk("b_word_done", b_done, (!pcs1 && b_cs));
      if (pcs1 && !b_cs) begin
        chk("b_pop_model_nonempty", (q1.size() > 0), 1);
        if (q1.size() > 0) exp1 = q1.pop_front();
        have1 = 1; nb1 = 0; low1 = 0; cap1 = '0;
      end
      if (!b_cs) begin
        low1++;
        if (pclk1 && !b_sclk) begin
          if (nb1 < BW) cap1[nb1] = b_mosi;
          nb1++;
        end
      end else begin
        chk("b_idle_sclk", b_sclk, 1);
        if (!pcs1) begin
          chk("b_frame_bits", nb1, BW); chk("b_frame_cs_low", low1, BW*2);
          if (have1) chk("b_frame_data", cap1, exp1);
          frames1++; have1 = 0;
        end
      end
      chk("b_level", b_level, q1.size());
    end
    pcs1 = b_cs; pclk1 = b_sclk;
  end

  task automatic wr0(input logic [DW-1:0] d, output int stall);
    stall = 0; wr_valid = 1'b1; wr_data = d;
    while (!wr_ready && stall < 1000) begin @(negedge clk); stall++; end
    chk("wr0_accept", wr_ready, 1);
    if (wr_ready) q0.push_back(d);
    @(negedge clk); wr_valid = 1'b0;
  endtask

  task automatic wr1(input logic [BW-1:0] d);
    int n = 0;
    b_wr_valid = 1'b1; b_wr_data = d;
    while (!b_wr_ready && n < 1000) begin @(negedge clk); n++; end
    chk("wr1_accept", b_wr_ready, 1);
    if (b_wr_ready) q1.push_back(d);
    @(negedge clk); b_wr_valid = 1'b0;
  endtask

  task automatic drain0();
    int n = 0;
    while (!(q0.size() == 0 && !busy && spi_cs) && n < 8000) begin @(negedge clk); n++; end
    chk("drain0_in_time", (n < 8000), 1);
  endtask

  task automatic drain1();
    int n = 0;
    while (!(q1.size() == 0 && !b_busy && b_cs) && n < 4000) begin @(negedge clk); n++; end
    chk("drain1_in_time", (n < 4000), 1);
  endtask

  task automatic wait_bits(input int nb);
    int n = 0;
    while (nbits0 != nb && n < 2000) begin @(negedge clk); n++; end
    chk("reach_bit", nbits0, nb);
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    int st, f0;
    repeat (3) @(negedge clk);
    RST = 1'b0;
    @(negedge clk);

    // Single word, first-frame latency, exact pin-level frame.
    wr0(24'h28BB85, st);
    chk("latency_edge_n", spi_cs, 1);
    @(negedge clk);
    chk("latency_edge_n1", spi_cs, 0);
    drain0();
    chk("single_frames", frames0, 1);

    // Narrow LSB-first instance.
    wr1(8'hA5);
    drain1();
    chk("b_a5_frames", frames1, 1);
    for (int i = 0; i < 6; i++) wr1(BW'($urandom));
    drain1();
    chk("b_total_frames", frames1, 7);

    // Back-pressure: 1 in flight + DEPTH queued, the sixth stalls until the next pop.
    f0 = frames0;
    for (int i = 0; i < 5; i++) begin
      wr0(DW'($urandom), st);
      chk("bp_no_stall", st, 0);
    end
    wr0(24'hC0FFEE, st);
    chk("bp_sixth_stall", st, FRAME0 + CS_GAP + 1 - DEPTH + 1);
    drain0();
    chk("bp_frames", frames0 - f0, 6);

    // Flush at bit 10 with three words queued; a write in the flush cycle is dropped.
    f0 = frames0;
    for (int i = 0; i < 4; i++) wr0(DW'($urandom), st);
    wait_bits(10);
    flush = 1'b1; wr_valid = 1'b1; wr_data = 24'hDEAD01;
    q0.delete();
    @(negedge clk);
    flush = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    chk("flush_no_frame", frames0 - f0, 0);
    wr0(24'h5A5A5A, st);
    drain0();
    chk("flush_then_frame", frames0 - f0, 1);

    // Reset held mid-frame.
    f0 = frames0;
    wr0(DW'($urandom), st);
    wr0(DW'($urandom), st);
    wait_bits(5);
    RST = 1'b1;
    q0.delete(); q1.delete();
    @(negedge clk);
    RST = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_no_frame", frames0 - f0, 0);

    // Random traffic with idle gaps so pointers wrap many times.
    f0 = frames0;
    for (int i = 0; i < 3*DEPTH + 20; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(10, 150)) @(negedge clk);
      wr0(DW'($urandom), st);
    end
    drain0();
    chk("random_frames", frames0 - f0, 3*DEPTH + 20);

    summary();
    $finish;
  end

  initial begin
    #600000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    summary();
    $finish;
  end
endmodule
